// File: rtl/decode.sv
// decode: folds PS/2 scan-code-set-2 prefix bytes (E0/F0/E1) into single key
// events, queues them in a small FIFO with a valid/ready port, and reports
// keyboard status bytes on sticky flags that never enter the queue.
module decode #(
    parameter int DEPTH     = 4,
    parameter int DROP_FAKE = 1
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic [7:0] word,
    input  logic       done,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_rel,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       bat_ok,
    output logic       kbd_err,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_E0    = 3'd1,
        S_F0    = 3'd2,
        S_E0F0  = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  skip;
    logic [2:0]  skip_nx;

    logic        done_q;
    logic        acc;

    // decoder outputs for the current accepted byte
    logic        emit;
    logic [7:0]  emit_code;
    logic        emit_ext;
    logic        emit_rel;
    logic        fake;
    logic        push;
    logic        set_bat;
    logic        set_err;

    // event FIFO
    logic [9:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        pop;
    logic        do_push;
    logic [9:0]  head;

    // A byte is taken only on the rising edge of the receiver's done level.
    assign acc = done & ~done_q;

    // done edge-detect register
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done;
        end
    end

    // prefix state and pause skip counter
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            skip  <= 3'd0;
        end else begin
            state <= state_nx;
            skip  <= skip_nx;
        end
    end

    // next-state decode of each accepted byte
    always_comb begin
        state_nx = state;
        skip_nx  = skip;
        if (acc) begin
            if (state == S_PAUSE) begin
                // Pause body bytes are swallowed whatever their value.
                skip_nx = skip - 3'd1;
                if (skip <= 3'd1) begin
                    state_nx = S_IDLE;
                end
            end else begin
                case (word)
                    8'hAA, 8'hFC, 8'h00, 8'hFF: state_nx = S_IDLE;
                    8'hE1: begin
                        state_nx = S_PAUSE;
                        skip_nx  = 3'd7;
                    end
                    8'hE0: state_nx = S_E0;
                    8'hF0: begin
                        if (state == S_IDLE) begin
                            state_nx = S_F0;
                        end else if (state == S_E0) begin
                            state_nx = S_E0F0;
                        end else begin
                            state_nx = state;
                        end
                    end
                    default: state_nx = S_IDLE;
                endcase
            end
        end
    end

    // event and status-flag outputs of the decoder
    always_comb begin
        emit      = 1'b0;
        emit_code = word;
        emit_ext  = 1'b0;
        emit_rel  = 1'b0;
        set_bat   = 1'b0;
        set_err   = 1'b0;
        if (acc) begin
            if (state == S_PAUSE) begin
                if (skip == 3'd1) begin
                    emit      = 1'b1;
                    emit_code = 8'hE1;
                    emit_ext  = 1'b1;
                    emit_rel  = 1'b0;
                end
            end else begin
                case (word)
                    8'hAA:                      set_bat = 1'b1;
                    8'hFC, 8'h00, 8'hFF:        set_err = 1'b1;
                    8'hE1, 8'hE0, 8'hF0: begin
                    end
                    default: begin
                        emit      = 1'b1;
                        emit_code = word;
                        emit_ext  = (state == S_E0) || (state == S_E0F0);
                        emit_rel  = (state == S_F0) || (state == S_E0F0);
                    end
                endcase
            end
        end
    end

    // Extended 0x12/0x59 are the keyboard's fake shifts around E0 keys.
    assign fake = (DROP_FAKE != 0) && emit_ext &&
                  ((emit_code == 8'h12) || (emit_code == 8'h59));
    assign push = emit & ~fake;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop     = ~empty & ev_ready;
    // A pop frees the slot on the same edge, so a full FIFO still accepts.
    assign do_push = push & (~full | pop);

    // FIFO pointers
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage (data only, no reset needed)
    always_ff @(posedge sysclk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= {emit_code, emit_ext, emit_rel};
        end
    end

    // sticky status flags, cleared only by reset
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            bat_ok   <= 1'b0;
            kbd_err  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (set_bat) begin
                bat_ok <= 1'b1;
            end
            if (set_err) begin
                kbd_err <= 1'b1;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Head fields are forced to zero while the queue is empty.
    assign head     = mem[rd_ptr[AW-1:0]];
    assign ev_valid = ~empty;
    assign ev_code  = empty ? 8'h00 : head[9:2];
    assign ev_ext   = empty ? 1'b0  : head[1];
    assign ev_rel   = empty ? 1'b0  : head[0];

endmodule

// File: tb/tb_decode.sv
// tb_decode: directed tests for the PS/2 byte-to-event decoder.
module tb_decode;

    logic       sysclk;
    logic       rst_n;
    logic [7:0] word;
    logic       done;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_rel;
    logic       ev_valid;
    logic       ev_ready;
    logic       bat_ok;
    logic       kbd_err;
    logic       overflow;

    int checks = 0;
    int passed = 0;

    logic [10:0] head;
    logic [2:0]  flags;
    assign head  = {ev_valid, ev_code, ev_ext, ev_rel};
    assign flags = {bat_ok, kbd_err, overflow};

    decode #(.DEPTH(4), .DROP_FAKE(1)) dut (
        .sysclk   (sysclk),
        .rst_n    (rst_n),
        .word     (word),
        .done     (done),
        .ev_code  (ev_code),
        .ev_ext   (ev_ext),
        .ev_rel   (ev_rel),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .bat_ok   (bat_ok),
        .kbd_err  (kbd_err),
        .overflow (overflow)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic do_reset();
        @(posedge sysclk);
        #3 rst_n = 1'b0;
        @(negedge sysclk);
        rst_n = 1'b1;
        @(posedge sysclk);
        #1;
    endtask

    // one byte: done high for one cycle, then low for one cycle
    task automatic send_byte(input logic [7:0] b);
        @(posedge sysclk);
        #1 word = b;
        done = 1'b1;
        @(posedge sysclk);
        #1 done = 1'b0;
        @(posedge sysclk);
        #1;
    endtask

    task automatic pop_one();
        ev_ready = 1'b1;
        @(posedge sysclk);
        #1 ev_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        @(posedge sysclk);
        @(posedge sysclk);
        #1;
        checks++;
        if (head !== 11'h000) $display("FAIL reset_head got %h want %h", head, 11'h000);
        else passed++;
        checks++;
        if (flags !== 3'b000) $display("FAIL reset_flags got %b want %b", flags, 3'b000);
        else passed++;
        @(negedge sysclk);
        rst_n = 1'b1;
    endtask

    task automatic test_make_break();
        @(posedge sysclk);
        #1 word = 8'h1C;
        done = 1'b1;
        @(negedge sysclk);
        checks++;
        if (ev_valid !== 1'b0) $display("FAIL latency_early got %b want %b", ev_valid, 1'b0);
        else passed++;
        @(posedge sysclk);
        #1;
        checks++;
        if (ev_valid !== 1'b1) $display("FAIL latency_on_time got %b want %b", ev_valid, 1'b1);
        else passed++;
        done = 1'b0;
        @(posedge sysclk);
        #1;
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++;
        if (head !== {1'b1, 8'h1C, 1'b0, 1'b0}) $display("FAIL make_1c got %h want %h", head, {1'b1, 8'h1C, 1'b0, 1'b0});
        else passed++;
        pop_one();
        checks++;
        if (head !== {1'b1, 8'h1C, 1'b0, 1'b1}) $display("FAIL break_1c got %h want %h", head, {1'b1, 8'h1C, 1'b0, 1'b1});
        else passed++;
        pop_one();
        checks++;
        if (ev_valid !== 1'b0) $display("FAIL make_break_empty got %b want %b", ev_valid, 1'b0);
        else passed++;
    endtask

    task automatic test_extended();
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'h12);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h59);
        checks++;
        if (head !== {1'b1, 8'h75, 1'b1, 1'b0}) $display("FAIL ext_make got %h want %h", head, {1'b1, 8'h75, 1'b1, 1'b0});
        else passed++;
        pop_one();
        checks++;
        if (head !== {1'b1, 8'h75, 1'b1, 1'b1}) $display("FAIL ext_break got %h want %h", head, {1'b1, 8'h75, 1'b1, 1'b1});
        else passed++;
        pop_one();
        checks++;
        if (ev_valid !== 1'b0) $display("FAIL fake_shift_dropped got %b want %b", ev_valid, 1'b0);
        else passed++;
        // a plain (non-extended) 0x12 is a real left shift and must pass
        send_byte(8'h12);
        checks++;
        if (head !== {1'b1, 8'h12, 1'b0, 1'b0}) $display("FAIL plain_shift got %h want %h", head, {1'b1, 8'h12, 1'b0, 1'b0});
        else passed++;
        pop_one();
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        for (int i = 0; i < 7; i++) send_byte(seq[i]);
        checks++;
        if (ev_valid !== 1'b0) $display("FAIL pause_early got %b want %b", ev_valid, 1'b0);
        else passed++;
        send_byte(seq[7]);
        checks++;
        if (head !== {1'b1, 8'hE1, 1'b1, 1'b0}) $display("FAIL pause_event got %h want %h", head, {1'b1, 8'hE1, 1'b1, 1'b0});
        else passed++;
        pop_one();
        checks++;
        if (ev_valid !== 1'b0) $display("FAIL pause_single got %b want %b", ev_valid, 1'b0);
        else passed++;
        send_byte(8'h1C);
        checks++;
        if (head !== {1'b1, 8'h1C, 1'b0, 1'b0}) $display("FAIL after_pause got %h want %h", head, {1'b1, 8'h1C, 1'b0, 1'b0});
        else passed++;
        pop_one();
    endtask

    task automatic test_status();
        send_byte(8'hAA);
        checks++;
        if ({bat_ok, ev_valid} !== 2'b10) $display("FAIL bat_ok got %b want %b", {bat_ok, ev_valid}, 2'b10);
        else passed++;
        send_byte(8'hE0); send_byte(8'hFC);
        checks++;
        if ({kbd_err, ev_valid} !== 2'b10) $display("FAIL kbd_err_fc got %b want %b", {kbd_err, ev_valid}, 2'b10);
        else passed++;
        send_byte(8'h1C);
        checks++;
        if (head !== {1'b1, 8'h1C, 1'b0, 1'b0}) $display("FAIL after_err got %h want %h", head, {1'b1, 8'h1C, 1'b0, 1'b0});
        else passed++;
        pop_one();
        do_reset();
        send_byte(8'h00);
        checks++;
        if (flags !== 3'b010) $display("FAIL kbd_err_00 got %b want %b", flags, 3'b010);
        else passed++;
        do_reset();
        send_byte(8'hFF);
        checks++;
        if ({flags, ev_valid} !== 4'b0100) $display("FAIL kbd_err_ff got %b want %b", {flags, ev_valid}, 4'b0100);
        else passed++;
        do_reset();
    endtask

    task automatic test_fifo();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        checks++;
        if ({overflow, head} !== {1'b0, 1'b1, 8'h11, 2'b00}) $display("FAIL fifo_full got %h want %h", {overflow, head}, {1'b0, 1'b1, 8'h11, 2'b00});
        else passed++;
        // push 0x55 and pop on the same edge while full
        @(posedge sysclk);
        #1 word = 8'h55;
        done = 1'b1;
        ev_ready = 1'b1;
        @(posedge sysclk);
        #1 done = 1'b0;
        ev_ready = 1'b0;
        checks++;
        if ({overflow, head} !== {1'b0, 1'b1, 8'h22, 2'b00}) $display("FAIL push_pop_full got %h want %h", {overflow, head}, {1'b0, 1'b1, 8'h22, 2'b00});
        else passed++;
        @(posedge sysclk);
        #1;
        send_byte(8'h66);
        checks++;
        if ({overflow, head} !== {1'b1, 1'b1, 8'h22, 2'b00}) $display("FAIL overflow got %h want %h", {overflow, head}, {1'b1, 1'b1, 8'h22, 2'b00});
        else passed++;
        pop_one();
        checks++;
        if (ev_code !== 8'h33) $display("FAIL order_33 got %h want %h", ev_code, 8'h33);
        else passed++;
        pop_one();
        checks++;
        if (ev_code !== 8'h44) $display("FAIL order_44 got %h want %h", ev_code, 8'h44);
        else passed++;
        pop_one();
        checks++;
        if (head !== {1'b1, 8'h55, 2'b00}) $display("FAIL order_55 got %h want %h", head, {1'b1, 8'h55, 2'b00});
        else passed++;
        pop_one();
        checks++;
        if (ev_valid !== 1'b0) $display("FAIL fifo_drained got %b want %b", ev_valid, 1'b0);
        else passed++;
        // done held high for 10 cycles counts as one byte
        @(posedge sysclk);
        #1 word = 8'h77;
        done = 1'b1;
        repeat (10) @(posedge sysclk);
        #1 done = 1'b0;
        @(posedge sysclk);
        #1;
        checks++;
        if (head !== {1'b1, 8'h77, 2'b00}) $display("FAIL held_done got %h want %h", head, {1'b1, 8'h77, 2'b00});
        else passed++;
        pop_one();
        checks++;
        if (ev_valid !== 1'b0) $display("FAIL held_done_single got %b want %b", ev_valid, 1'b0);
        else passed++;
    endtask

    task automatic test_back_to_back();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        ev_ready = 1'b1;
        checks++;
        if (ev_code !== 8'h11) $display("FAIL b2b_0 got %h want %h", ev_code, 8'h11);
        else passed++;
        @(posedge sysclk);
        #1;
        checks++;
        if (ev_code !== 8'h22) $display("FAIL b2b_1 got %h want %h", ev_code, 8'h22);
        else passed++;
        @(posedge sysclk);
        #1;
        checks++;
        if (ev_code !== 8'h33) $display("FAIL b2b_2 got %h want %h", ev_code, 8'h33);
        else passed++;
        @(posedge sysclk);
        #1;
        checks++;
        if (ev_valid !== 1'b0) $display("FAIL b2b_empty got %b want %b", ev_valid, 1'b0);
        else passed++;
        ev_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'hE0); send_byte(8'hF0);
        checks++;
        if ({overflow, ev_valid} !== 2'b11) $display("FAIL pre_reset got %b want %b", {overflow, ev_valid}, 2'b11);
        else passed++;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({flags, head} !== 14'h0) $display("FAIL async_reset got %h want %h", {flags, head}, 14'h0);
        else passed++;
        @(negedge sysclk);
        rst_n = 1'b1;
        send_byte(8'h75);
        checks++;
        if (head !== {1'b1, 8'h75, 1'b0, 1'b0}) $display("FAIL post_reset got %h want %h", head, {1'b1, 8'h75, 1'b0, 1'b0});
        else passed++;
        pop_one();
    endtask

    initial begin
        rst_n    = 1'b1;
        done     = 1'b0;
        word     = 8'h00;
        ev_ready = 1'b0;
        test_reset();
        test_make_break();
        test_extended();
        test_pause();
        test_status();
        test_fifo();
        test_back_to_back();
        // leave overflow set so the async reset visibly clears it
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
        do_reset();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
        pop_one(); pop_one(); pop_one(); pop_one();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
